// File: rtl/clock_pkg.sv
// clock_pkg: shared alarm FSM states, BCD limits and the 12-hour display mapping.
package clock_pkg;
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} alarm_state_e;
  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_23 = 8'h23;
  localparam logic [7:0] BCD_12 = 8'h12;
  localparam logic [7:0] BCD_07 = 8'h07;
  // 13-23 -> 01-11 done digit-wise so no binary conversion is needed
  function automatic logic [7:0] to_12h(input logic [7:0] h);
    return h == 8'h00 ? BCD_12 : h <= BCD_12 ? h :
           h[3:0] >= 4'd2 ? {h[7:4] - 4'd1, h[3:0] - 4'd2} : {h[7:4] - 4'd2, h[3:0] + 4'd8};
  endfunction
endpackage

// File: rtl/bcd_wrap_counter.sv
// bcd_wrap_counter: two-digit BCD counter wrapping MAX -> 00 with sync active-low clear.
module bcd_wrap_counter import clock_pkg::*; #(
  parameter logic [7:0] MAX = BCD_59,
  parameter logic [7:0] RST = 8'h00
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic       inc,
  output logic [7:0] value,
  output logic [7:0] nxt,
  output logic       carry
);
  logic [7:0] value_q, value_d;
  always_comb
    value_d = !n_clr ? RST : !inc ? value_q : value_q == MAX ? 8'h00 :
              value_q[3:0] == 4'h9 ? {value_q[7:4] + 4'd1, 4'h0} : value_q + 8'h01;
  always_ff @(posedge clk) value_q <= value_d;
  assign value = value_q;
  assign nxt   = value_d;
  assign carry = inc && value_q == MAX;
endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: BCD timekeeper with internal 1 Hz prescaler, 12/24h display and ring/snooze alarm.
module alarm_clock_core import clock_pkg::*; #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int RING_SEC      = 60,
  parameter int SNOOZE_SEC    = 300
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       En,
  input  logic       Mode12,
  input  logic       AdjMinKey,
  input  logic       AdjHrKey,
  input  logic       AlarmSetKey,
  input  logic       AlarmEn,
  input  logic       SnoozeKey,
  input  logic       AlarmOff,
  output logic [7:0] Hour,
  output logic       PM,
  output logic [7:0] Minute,
  output logic [7:0] Second,
  output logic [7:0] AlarmHour,
  output logic [7:0] AlarmMinute,
  output logic       Ring,
  output logic       Tick
);
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int RW = $clog2(RING_SEC + 1);
  localparam int SW = $clog2(SNOOZE_SEC + 1);
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d, pre_wrap;
  always_comb begin
    pre_wrap = En && pre_q == PW'(TICKS_PER_SEC - 1);
    pre_d    = !nCR ? '0 : !En ? pre_q : pre_wrap ? '0 : pre_q + PW'(1);
    tick_d   = nCR && pre_wrap;
  end
  always_ff @(posedge CP) begin
    pre_q  <= pre_d;
    tick_q <= tick_d;
  end
  logic [7:0] sec_q, min_q, hr_q, am_q, ah_q, sec_n, min_n, hr_n, am_n, ah_n;
  logic sec_c, min_c, hr_c, am_c, ah_c, t_min, t_hr, min_inc, hr_inc;
  // a held adjust key replaces the natural carry into its field
  always_comb begin
    t_min   = AdjMinKey && !AlarmSetKey;
    t_hr    = AdjHrKey && !AlarmSetKey;
    min_inc = tick_q && (t_min || sec_c);
    hr_inc  = tick_q && (t_hr || (!t_min && min_c));
  end
  bcd_wrap_counter #(.MAX(BCD_59), .RST(8'h00)) u_sec (.clk(CP), .n_clr(nCR), .inc(tick_q),
    .value(sec_q), .nxt(sec_n), .carry(sec_c));
  bcd_wrap_counter #(.MAX(BCD_59), .RST(8'h00)) u_min (.clk(CP), .n_clr(nCR), .inc(min_inc),
    .value(min_q), .nxt(min_n), .carry(min_c));
  bcd_wrap_counter #(.MAX(BCD_23), .RST(8'h00)) u_hr (.clk(CP), .n_clr(nCR), .inc(hr_inc),
    .value(hr_q), .nxt(hr_n), .carry(hr_c));
  bcd_wrap_counter #(.MAX(BCD_59), .RST(8'h00)) u_amin (.clk(CP), .n_clr(nCR),
    .inc(tick_q && AlarmSetKey && AdjMinKey), .value(am_q), .nxt(am_n), .carry(am_c));
  bcd_wrap_counter #(.MAX(BCD_23), .RST(BCD_07)) u_ahr (.clk(CP), .n_clr(nCR),
    .inc(tick_q && AlarmSetKey && AdjHrKey), .value(ah_q), .nxt(ah_n), .carry(ah_c));
  logic unused_ok;
  assign unused_ok = &{hr_c, am_c, ah_c, am_n, ah_n};
  logic match;
  assign match = tick_q && AlarmEn && hr_n == ah_q && min_n == am_q && sec_n == 8'h00;
  alarm_state_e state_q;
  logic [RW-1:0] ring_cnt_q;
  logic [SW-1:0] snz_cnt_q;
  logic ring_q;
  always_ff @(posedge CP) begin
    if (!nCR) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ring_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (match) begin
          state_q    <= RING;
          ring_cnt_q <= RW'(RING_SEC);
          ring_q     <= 1'b1;
        end
        RING: if (AlarmOff || !AlarmEn) begin
          state_q <= IDLE;
          ring_q  <= 1'b0;
        end else if (SnoozeKey) begin
          state_q   <= SNOOZE;
          snz_cnt_q <= SW'(SNOOZE_SEC);
          ring_q    <= 1'b0;
        end else if (tick_q) begin
          ring_cnt_q <= ring_cnt_q - RW'(1);
          if (ring_cnt_q == RW'(1)) begin
            state_q <= IDLE;
            ring_q  <= 1'b0;
          end
        end
        SNOOZE: if (AlarmOff || !AlarmEn) begin
          state_q <= IDLE;
        end else if (tick_q) begin
          snz_cnt_q <= snz_cnt_q - SW'(1);
          if (snz_cnt_q == SW'(1)) begin
            state_q    <= RING;
            ring_cnt_q <= RW'(RING_SEC);
            ring_q     <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Hour        = Mode12 ? to_12h(hr_q) : hr_q;
  assign PM          = hr_q >= BCD_12;
  assign Minute      = min_q;
  assign Second      = sec_q;
  assign AlarmHour   = ah_q;
  assign AlarmMinute = am_q;
  assign Ring        = ring_q;
  assign Tick        = tick_q;
endmodule

// File: tb/tb_alarm_clock_core.sv
// tb_alarm_clock_core: directed self-checking bench with TICKS_PER_SEC=4, RING_SEC=3, SNOOZE_SEC=5.
module tb_alarm_clock_core;
  logic CP = 1'b0, nCR = 1'b0, En = 1'b1, Mode12 = 1'b0;
  logic AdjMinKey = 1'b0, AdjHrKey = 1'b0, AlarmSetKey = 1'b0, AlarmEn = 1'b0;
  logic SnoozeKey = 1'b0, AlarmOff = 1'b0;
  logic [7:0] Hour, Minute, Second, AlarmHour, AlarmMinute;
  logic PM, Ring, Tick;
  int checks = 0, errors = 0;
  alarm_clock_core #(.TICKS_PER_SEC(4), .RING_SEC(3), .SNOOZE_SEC(5)) dut (
    .CP(CP), .nCR(nCR), .En(En), .Mode12(Mode12), .AdjMinKey(AdjMinKey), .AdjHrKey(AdjHrKey),
    .AlarmSetKey(AlarmSetKey), .AlarmEn(AlarmEn), .SnoozeKey(SnoozeKey), .AlarmOff(AlarmOff),
    .Hour(Hour), .PM(PM), .Minute(Minute), .Second(Second), .AlarmHour(AlarmHour),
    .AlarmMinute(AlarmMinute), .Ring(Ring), .Tick(Tick));
  always #5 CP = ~CP;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    check({tag, "_hour"}, Hour, h);
    check({tag, "_min"}, Minute, m);
    check({tag, "_sec"}, Second, s);
  endtask
  // called at a negedge; returns at the negedge just after the tick's update edge
  task automatic tick_step(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!Tick && w < 16) begin
        @(negedge CP);
        w++;
      end
      if (!Tick) begin
        check("tick_timeout", {7'b0, Tick}, 8'h01);
        return;
      end
      @(negedge CP);
    end
  endtask
  initial begin
    repeat (3) @(negedge CP);
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset_ahour", AlarmHour, 8'h07);
    check("reset_amin", AlarmMinute, 8'h00);
    check("reset_ring", {7'b0, Ring}, 8'h00);
    check("reset_tick", {7'b0, Tick}, 8'h00);
    nCR = 1'b1;
    repeat (3) @(negedge CP);
    check("tick_early", {7'b0, Tick}, 8'h00);
    @(negedge CP);
    check("tick_first", {7'b0, Tick}, 8'h01);
    tick_step(60);
    check_time("sixty", 8'h00, 8'h01, 8'h00);
    AdjMinKey = 1'b1; AdjHrKey = 1'b1;
    tick_step(23);
    AdjHrKey = 1'b0;
    tick_step(35);
    AdjMinKey = 1'b0;
    check_time("preload", 8'h23, 8'h59, 8'h58);
    tick_step(2);
    check_time("midnight", 8'h00, 8'h00, 8'h00);
    Mode12 = 1'b1;
    #1 check("h12_midnight", Hour, 8'h12);
    check("pm_midnight", {7'b0, PM}, 8'h00);
    AdjMinKey = 1'b1; AdjHrKey = 1'b1;
    tick_step(5);
    AdjMinKey = 1'b0;
    tick_step(8);
    AdjHrKey = 1'b0;
    check_time("h12_1305", 8'h01, 8'h05, 8'h13);
    check("pm_1305", {7'b0, PM}, 8'h01);
    Mode12 = 1'b0;
    #1 check("h24_1305", Hour, 8'h13);
    AdjMinKey = 1'b1; AdjHrKey = 1'b1;
    tick_step(21);
    AdjHrKey = 1'b0;
    tick_step(33);
    check_time("pre_minwrap", 8'h10, 8'h59, 8'h07);
    tick_step(1);
    AdjMinKey = 1'b0;
    check_time("minwrap", 8'h10, 8'h00, 8'h08);
    AdjMinKey = 1'b1; AdjHrKey = 1'b1;
    tick_step(20);
    AdjHrKey = 1'b0;
    tick_step(38);
    AdjMinKey = 1'b0;
    check_time("pre_alarm_adj", 8'h06, 8'h58, 8'h06);
    AlarmEn = 1'b1;
    tick_step(113);
    check_time("pre_alarm", 8'h06, 8'h59, 8'h59);
    check("ring_idle", {7'b0, Ring}, 8'h00);
    tick_step(1);
    check_time("alarm_hit", 8'h07, 8'h00, 8'h00);
    check("ring_on", {7'b0, Ring}, 8'h01);
    tick_step(2);
    check("ring_hold", {7'b0, Ring}, 8'h01);
    tick_step(1);
    check("ring_timeout", {7'b0, Ring}, 8'h00);
    AlarmSetKey = 1'b1; AdjMinKey = 1'b1;
    tick_step(2);
    AlarmSetKey = 1'b0; AdjMinKey = 1'b0;
    check("aset_amin", AlarmMinute, 8'h02);
    check("aset_ahour", AlarmHour, 8'h07);
    check_time("aset_time", 8'h07, 8'h00, 8'h05);
    tick_step(114);
    check("ring_before2", {7'b0, Ring}, 8'h00);
    tick_step(1);
    check("ring_on2", {7'b0, Ring}, 8'h01);
    SnoozeKey = 1'b1;
    @(negedge CP);
    SnoozeKey = 1'b0;
    check("snooze_off", {7'b0, Ring}, 8'h00);
    tick_step(4);
    check("snooze_hold", {7'b0, Ring}, 8'h00);
    tick_step(1);
    check("snooze_rering", {7'b0, Ring}, 8'h01);
    SnoozeKey = 1'b1; AlarmOff = 1'b1;
    @(negedge CP);
    SnoozeKey = 1'b0; AlarmOff = 1'b0;
    check("off_prio", {7'b0, Ring}, 8'h00);
    tick_step(6);
    check("off_stays", {7'b0, Ring}, 8'h00);
    AlarmSetKey = 1'b1; AdjMinKey = 1'b1;
    tick_step(2);
    AlarmSetKey = 1'b0; AdjMinKey = 1'b0;
    tick_step(106);
    check_time("pre_alarm3", 8'h07, 8'h03, 8'h59);
    tick_step(1);
    check("ring_on3", {7'b0, Ring}, 8'h01);
    SnoozeKey = 1'b1;
    @(negedge CP);
    SnoozeKey = 1'b0;
    tick_step(2);
    check("snooze3", {7'b0, Ring}, 8'h00);
    nCR = 1'b0;
    @(negedge CP);
    check("rst_ring", {7'b0, Ring}, 8'h00);
    check_time("rst_time", 8'h00, 8'h00, 8'h00);
    check("rst_ahour", AlarmHour, 8'h07);
    check("rst_amin", AlarmMinute, 8'h00);
    nCR = 1'b1;
    repeat (2) @(negedge CP);
    En = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CP);
      check("frozen_tick", {7'b0, Tick}, 8'h00);
    end
    check_time("frozen", 8'h00, 8'h00, 8'h00);
    check("frozen_ring", {7'b0, Ring}, 8'h00);
    En = 1'b1;
    @(negedge CP);
    check("resume_early", {7'b0, Tick}, 8'h00);
    @(negedge CP);
    check("resume_tick", {7'b0, Tick}, 8'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_clock_core.md
Name: alarm_clock_core

Overview:
Parametrised successor to the team's 24-hour BCD timekeeper. It runs from one fast system clock and generates its own 1 Hz tick internally rather than taking a divided clock. It adds a 12/24-hour display mode, an alarm register with its own adjust path, and an alarm ring/snooze state machine. It sits between the board oscillator and the 7-segment/annunciator drivers.

Parameters:
TICKS_PER_SEC, 1000, CP cycles per second; must be >= 2.
RING_SEC, 60, seconds Ring stays asserted when no key is pressed.
SNOOZE_SEC, 300, seconds spent in snooze before re-ringing.

Ports:
CP  input  1  system clock, rising edge.
nCR  input  1  reset, synchronous, active-low.
En  input  1  count enable; when low the prescaler freezes.
Mode12  input  1  1 = 12-hour display, 0 = 24-hour display.
AdjMinKey  input  1  level; advance minute once per tick.
AdjHrKey  input  1  level; advance hour once per tick.
AlarmSetKey  input  1  level; routes the Adj keys to the alarm registers instead of the time registers.
AlarmEn  input  1  alarm armed.
SnoozeKey  input  1  level, sampled each CP.
AlarmOff  input  1  level, sampled each CP.
Hour  output  8  BCD display hour: 00-23, or 01-12 when Mode12=1.
PM  output  1  1 when internal hour >= 12, in both modes.
Minute  output  8  BCD 00-59.
Second  output  8  BCD 00-59.
AlarmHour  output  8  BCD alarm hour, always 24-hour format.
AlarmMinute  output  8  BCD alarm minute.
Ring  output  1  alarm sounding.
Tick  output  1  one-CP pulse per second.

Behaviour:
- Reset is synchronous: nCR=0 at a CP edge sets:
  - time to 00:00:00; AlarmHour=8'h07, AlarmMinute=8'h00;
  - prescaler to 0; Tick=0; Ring=0; FSM to IDLE; ring and snooze counters to 0.
  - Reset asserted mid-ring or mid-snooze behaves the same way.
- Prescaler:
  - counts 0..TICKS_PER_SEC-1 while En=1;
  - Tick=1, registered, on the cycle after the prescaler wraps, so the first Tick comes TICKS_PER_SEC cycles after reset release;
  - En=0 holds the count and issues no Tick.
- All state updates below occur only on a Tick cycle, except the key responses in the ring FSM.
- Time counting (BCD, internal 24-hour):
  - Second 59→00 carries into Minute;
  - Minute 59→00 with the second carry carries into Hour;
  - Hour 23→00 wraps.
- Time adjust (AlarmSetKey=0):
  - AdjMinKey: Minute+1 per tick, wraps 59→00, never carries into Hour; the natural second carry is suppressed that tick.
  - AdjHrKey: Hour+1 per tick, wraps 23→00; the natural minute carry is suppressed.
  - Both keys held: both fields advance. Seconds keep counting throughout.
- Alarm adjust (AlarmSetKey=1):
  - the Adj keys advance AlarmMinute and AlarmHour with the same wrap rules;
  - the time registers count normally.
- Display mapping is combinational from the registers:
  - Mode12=0: Hour equals the internal hour.
  - Mode12=1: internal 00→12; 01-11 unchanged; 12→12; 13-23→h-12.
- Alarm FSM states:
  - IDLE: go to RING on a Tick when AlarmEn=1 and the post-update time equals AlarmHour:AlarmMinute:00. Load ring counter with RING_SEC. SnoozeKey and AlarmOff are ignored.
  - RING: Ring=1. Ring counter decrements each Tick; reaching 0 returns to IDLE. AlarmOff=1 or AlarmEn=0 returns to IDLE next cycle. Otherwise SnoozeKey=1 goes to SNOOZE and loads the snooze counter with SNOOZE_SEC. AlarmOff has priority over SnoozeKey.
  - SNOOZE: Ring=0. Snooze counter decrements each Tick; reaching 0 goes to RING and reloads RING_SEC. AlarmOff or AlarmEn=0 returns to IDLE.
- A time match while already in RING or SNOOZE does not restart the sequence.
- Adjusting time onto the alarm time triggers RING only when the resulting second is 00.
- Ring is registered and changes on the cycle after the FSM transition condition.

Decomposition:
- Shared package clock_pkg holds:
  - alarm FSM state enum {IDLE, RING, SNOOZE};
  - BCD constants 8'h59, 8'h23, 8'h12, 8'h07.
- One sub-module: bcd_wrap_counter. It is a two-digit BCD counter with parameter MAX (8'h59 or 8'h23), inc input, synchronous active-low clear, reset-value parameter, and carry output asserted when value==MAX and inc=1.
- It is instantiated five times: seconds, minutes, hours, alarm minutes, alarm hours.

Test Plan:
- TICKS_PER_SEC=4. Release reset, En=1 → first Tick at cycle 4. After 60 Ticks: Minute=8'h01, Second=8'h00.
- Preload 23:59:58 via AdjHrKey/AdjMinKey, then 2 Ticks → 00:00:00. Mode12=1 gives Hour=8'h12, PM=0. At 13:05, Mode12=1 gives Hour=8'h01, PM=1.
- AdjMinKey held from Minute=8'h59, Hour=8'h10 → next Tick Minute=8'h00, Hour remains 8'h10.
- Alarm 07:00, AlarmEn=1, time 06:59:59 → Tick gives 07:00:00 and Ring=1 next cycle. With no keys and RING_SEC=3, Ring=0 after 3 Ticks.
- While ringing, SnoozeKey pulse → Ring=0. With SNOOZE_SEC=5, after 5 Ticks Ring=1 again. Then AlarmOff and SnoozeKey together → IDLE, Ring=0.
- nCR=0 during SNOOZE → next edge gives Ring=0, time 00:00:00, Alarm 07:00. With En=0, the prescaler and time stay frozen for 20 cycles.
